// File: rtl/prim_edge_sequencer_pkg.sv
// prim_edge_sequencer_pkg
// Shared definitions for the primitive edge sequencer:
//   - sequencer state encoding
//   - primitive type codes found in word 1 of each record
//   - record stride and word offsets inside a 9-word record
//   - edge index codes used by the endpoint selector
//   - saturating 8-bit increment helper for the primitive counter
package prim_edge_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LATCH     = 3'd2,
    ST_EMIT      = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_NEXT      = 3'd5,
    ST_FINISH    = 3'd6,
    ST_ERROR     = 3'd7
  } state_e;

  // Primitive type codes (full-word compare; any other value is an error)
  localparam int unsigned TYPE_END      = 32'd0;
  localparam int unsigned TYPE_LINE     = 32'd1;
  localparam int unsigned TYPE_TRIANGLE = 32'd3;

  // Record layout: stride and word offsets relative to the record base
  localparam int unsigned REC_STRIDE   = 32'd9;
  localparam int unsigned REC_LAST_OFS = 32'd8;
  localparam int unsigned W_TYPE       = 32'd0;
  localparam int unsigned W_X0         = 32'd1;
  localparam int unsigned W_Y0         = 32'd2;
  localparam int unsigned W_X1         = 32'd3;
  localparam int unsigned W_Y1         = 32'd4;
  localparam int unsigned W_X2         = 32'd5;
  localparam int unsigned W_Y2         = 32'd6;
  localparam int unsigned W_COLOR      = 32'd7;
  localparam int unsigned W_RSVD       = 32'd8;

  // Edge index codes: which vertex pair forms the current edge
  localparam logic [1:0] EDGE_V0V1 = 2'd0;
  localparam logic [1:0] EDGE_V1V2 = 2'd1;
  localparam logic [1:0] EDGE_V2V0 = 2'd2;

  // Primitive counter increment that sticks at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/prim_edge_sequencer_edge_select.sv
// edge_select
// Combinational endpoint selector: maps an edge index onto the pair of
// triangle vertices that forms that edge (0: v0->v1, 1: v1->v2, 2: v2->v0).
// Ports:
//   edge_idx           edge index 0..2
//   v0_x..v2_y         vertex coordinates
//   x0, y0, x1, y1     selected edge start and end point
module edge_select
  import prim_edge_sequencer_pkg::*;
#(
  parameter int COORD_WIDTH = 10
) (
  input  logic [1:0]             edge_idx,
  input  logic [COORD_WIDTH-1:0] v0_x,
  input  logic [COORD_WIDTH-1:0] v0_y,
  input  logic [COORD_WIDTH-1:0] v1_x,
  input  logic [COORD_WIDTH-1:0] v1_y,
  input  logic [COORD_WIDTH-1:0] v2_x,
  input  logic [COORD_WIDTH-1:0] v2_y,
  output logic [COORD_WIDTH-1:0] x0,
  output logic [COORD_WIDTH-1:0] y0,
  output logic [COORD_WIDTH-1:0] x1,
  output logic [COORD_WIDTH-1:0] y1
);

  // Vertex pair selection for the requested edge
  always_comb begin
    x0 = v0_x;
    y0 = v0_y;
    x1 = v1_x;
    y1 = v1_y;
    case (edge_idx)
      EDGE_V0V1: begin
        x0 = v0_x; y0 = v0_y; x1 = v1_x; y1 = v1_y;
      end
      EDGE_V1V2: begin
        x0 = v1_x; y0 = v1_y; x1 = v2_x; y1 = v2_y;
      end
      EDGE_V2V0: begin
        x0 = v2_x; y0 = v2_y; x1 = v0_x; y1 = v0_y;
      end
      default: begin
        x0 = v0_x; y0 = v0_y; x1 = v1_x; y1 = v1_y;
      end
    endcase
  end

endmodule

// File: rtl/prim_edge_sequencer.sv
// prim_edge_sequencer
// Walks 9-word primitive records in RAM (type, x0,y0,x1,y1,x2,y2, colour,
// reserved) starting at address 0 and hands each edge to a line rasterizer
// through a valid/ready handshake, waiting for line_done between edges.
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   load_finish                   RAM contents are ready; starts the walk
//   ram_read_addr                 base address of the current record
//   ram_read_data1..9             RAM[ram_read_addr+k-1]
//   line_x0/y0/x1/y1, line_color  current edge command
//   line_valid, line_ready        edge command handshake
//   line_done                     rasterizer finished the accepted edge
//   busy, done, error, prim_count status
// Optional feature: define DEGENERATE_CULL_EN to skip edges whose two
// endpoints are identical instead of emitting them.
module prim_edge_sequencer
  import prim_edge_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int COORD_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_finish,
  output logic [ADDR_WIDTH-1:0]  ram_read_addr,
  input  logic [DATA_WIDTH-1:0]  ram_read_data1,
  input  logic [DATA_WIDTH-1:0]  ram_read_data2,
  input  logic [DATA_WIDTH-1:0]  ram_read_data3,
  input  logic [DATA_WIDTH-1:0]  ram_read_data4,
  input  logic [DATA_WIDTH-1:0]  ram_read_data5,
  input  logic [DATA_WIDTH-1:0]  ram_read_data6,
  input  logic [DATA_WIDTH-1:0]  ram_read_data7,
  input  logic [DATA_WIDTH-1:0]  ram_read_data8,
  input  logic [DATA_WIDTH-1:0]  ram_read_data9,
  output logic [COORD_WIDTH-1:0] line_x0,
  output logic [COORD_WIDTH-1:0] line_y0,
  output logic [COORD_WIDTH-1:0] line_x1,
  output logic [COORD_WIDTH-1:0] line_y1,
  output logic [DATA_WIDTH-1:0]  line_color,
  output logic                   line_valid,
  input  logic                   line_ready,
  input  logic                   line_done,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [7:0]             prim_count
);

  state_e                 state_r, state_next_s;
  logic [ADDR_WIDTH-1:0]  base_r;
  logic [7:0]             prim_count_r;
  logic [COORD_WIDTH-1:0] vx_r [3];
  logic [COORD_WIDTH-1:0] vy_r [3];
  logic                   is_tri_r;
  logic [1:0]             edge_idx_r;
  logic [COORD_WIDTH-1:0] line_x0_r, line_y0_r, line_x1_r, line_y1_r;
  logic [DATA_WIDTH-1:0]  line_color_r;
  logic                   line_valid_r, busy_r, done_r, error_r;

  logic [DATA_WIDTH-1:0]  word_s [9];
  logic [COORD_WIDTH-1:0] rx_s [3];
  logic [COORD_WIDTH-1:0] ry_s [3];
  logic [COORD_WIDTH-1:0] sel_vx_s [3];
  logic [COORD_WIDTH-1:0] sel_vy_s [3];
  logic [COORD_WIDTH-1:0] sel_x0_s, sel_y0_s, sel_x1_s, sel_y1_s;
  logic [1:0]             sel_idx_s;
  logic [ADDR_WIDTH:0]    rec_end_s;
  logic                   overflow_s, last_edge_s, keep_s;
  logic                   latch_s, load_line_s, advance_s, accept_s;
  logic                   unused_s;

  assign word_s[0] = ram_read_data1;
  assign word_s[1] = ram_read_data2;
  assign word_s[2] = ram_read_data3;
  assign word_s[3] = ram_read_data4;
  assign word_s[4] = ram_read_data5;
  assign word_s[5] = ram_read_data6;
  assign word_s[6] = ram_read_data7;
  assign word_s[7] = ram_read_data8;
  assign word_s[8] = ram_read_data9;

  assign rx_s[0] = word_s[W_X0][COORD_WIDTH-1:0];
  assign ry_s[0] = word_s[W_Y0][COORD_WIDTH-1:0];
  assign rx_s[1] = word_s[W_X1][COORD_WIDTH-1:0];
  assign ry_s[1] = word_s[W_Y1][COORD_WIDTH-1:0];
  assign rx_s[2] = word_s[W_X2][COORD_WIDTH-1:0];
  assign ry_s[2] = word_s[W_Y2][COORD_WIDTH-1:0];

  // Upper coordinate bits and the reserved word carry no meaning here
  assign unused_s = ^{word_s[W_RSVD], ram_read_data2, ram_read_data3,
                      ram_read_data4, ram_read_data5, ram_read_data6,
                      ram_read_data7};

  // Last word of the following record must still be addressable
  assign rec_end_s   = {1'b0, base_r} + (ADDR_WIDTH+1)'(REC_STRIDE + REC_LAST_OFS);
  assign overflow_s  = rec_end_s[ADDR_WIDTH];
  assign last_edge_s = is_tri_r ? (edge_idx_r == EDGE_V2V0) : 1'b1;

  // Vertex source: live RAM words while latching, stored vertices afterwards
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (latch_s) begin
        sel_vx_s[i] = rx_s[i];
        sel_vy_s[i] = ry_s[i];
      end else begin
        sel_vx_s[i] = vx_r[i];
        sel_vy_s[i] = vy_r[i];
      end
    end
  end

  edge_select #(.COORD_WIDTH(COORD_WIDTH)) u_edge_select (
    .edge_idx (sel_idx_s),
    .v0_x     (sel_vx_s[0]),
    .v0_y     (sel_vy_s[0]),
    .v1_x     (sel_vx_s[1]),
    .v1_y     (sel_vy_s[1]),
    .v2_x     (sel_vx_s[2]),
    .v2_y     (sel_vy_s[2]),
    .x0       (sel_x0_s),
    .y0       (sel_y0_s),
    .x1       (sel_x1_s),
    .y1       (sel_y1_s)
  );

`ifdef DEGENERATE_CULL_EN
  // A zero-length edge is loaded with line_valid low and skipped in EMIT
  assign keep_s = ~((sel_x0_s == sel_x1_s) && (sel_y0_s == sel_y1_s));
`else
  assign keep_s = 1'b1;
`endif

  // Next-state and control strobes
  always_comb begin
    state_next_s = state_r;
    latch_s      = 1'b0;
    load_line_s  = 1'b0;
    advance_s    = 1'b0;
    accept_s     = 1'b0;
    sel_idx_s    = edge_idx_r + 2'd1;
    case (state_r)
      ST_IDLE: begin
        if (load_finish) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_next_s = ST_LATCH;
      end
      ST_LATCH: begin
        if (word_s[W_TYPE] == DATA_WIDTH'(TYPE_END)) begin
          state_next_s = ST_FINISH;
        end else if ((word_s[W_TYPE] == DATA_WIDTH'(TYPE_LINE)) ||
                     (word_s[W_TYPE] == DATA_WIDTH'(TYPE_TRIANGLE))) begin
          state_next_s = ST_EMIT;
          latch_s      = 1'b1;
          load_line_s  = 1'b1;
          sel_idx_s    = EDGE_V0V1;
        end else begin
          state_next_s = ST_ERROR;
        end
      end
      ST_EMIT: begin
        // line_valid low in EMIT only happens for a culled edge
        if (!line_valid_r) begin
          if (last_edge_s) begin
            state_next_s = ST_NEXT;
          end else begin
            state_next_s = ST_EMIT;
            load_line_s  = 1'b1;
            advance_s    = 1'b1;
          end
        end else if (line_ready) begin
          state_next_s = ST_WAIT_DONE;
          accept_s     = 1'b1;
        end else begin
          state_next_s = ST_EMIT;
        end
      end
      ST_WAIT_DONE: begin
        if (!line_done) begin
          state_next_s = ST_WAIT_DONE;
        end else if (last_edge_s) begin
          state_next_s = ST_NEXT;
        end else begin
          state_next_s = ST_EMIT;
          load_line_s  = 1'b1;
          advance_s    = 1'b1;
        end
      end
      ST_NEXT: begin
        if (overflow_s) begin
          state_next_s = ST_ERROR;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_FINISH: begin
        state_next_s = ST_FINISH;
      end
      ST_ERROR: begin
        state_next_s = ST_ERROR;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath, edge command and status registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      base_r       <= '0;
      prim_count_r <= 8'd0;
      is_tri_r     <= 1'b0;
      edge_idx_r   <= 2'd0;
      line_x0_r    <= '0;
      line_y0_r    <= '0;
      line_x1_r    <= '0;
      line_y1_r    <= '0;
      line_color_r <= '0;
      line_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        vx_r[i] <= '0;
        vy_r[i] <= '0;
      end
    end else begin
      busy_r  <= !(state_next_s inside {ST_IDLE, ST_FINISH, ST_ERROR});
      done_r  <= (state_next_s == ST_FINISH);
      error_r <= (state_next_s == ST_ERROR);
      if ((state_r == ST_IDLE) && load_finish) begin
        base_r <= '0;
      end
      if (latch_s) begin
        for (int i = 0; i < 3; i++) begin
          vx_r[i] <= rx_s[i];
          vy_r[i] <= ry_s[i];
        end
        is_tri_r     <= (word_s[W_TYPE] == DATA_WIDTH'(TYPE_TRIANGLE));
        line_color_r <= word_s[W_COLOR];
        edge_idx_r   <= EDGE_V0V1;
      end else if (advance_s) begin
        edge_idx_r <= edge_idx_r + 2'd1;
      end
      if (load_line_s) begin
        line_x0_r    <= sel_x0_s;
        line_y0_r    <= sel_y0_s;
        line_x1_r    <= sel_x1_s;
        line_y1_r    <= sel_y1_s;
        line_valid_r <= keep_s;
      end else if (accept_s) begin
        line_valid_r <= 1'b0;
      end
      if (state_r == ST_NEXT) begin
        prim_count_r <= sat_inc8(prim_count_r);
        if (!overflow_s) begin
          base_r <= base_r + ADDR_WIDTH'(REC_STRIDE);
        end
      end
    end
  end

  assign ram_read_addr = base_r;
  assign line_x0       = line_x0_r;
  assign line_y0       = line_y0_r;
  assign line_x1       = line_x1_r;
  assign line_y1       = line_y1_r;
  assign line_color    = line_color_r;
  assign line_valid    = line_valid_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;
  assign prim_count    = prim_count_r;

endmodule

// File: doc/prim_edge_sequencer.md
PRIM_EDGE_SEQUENCER -- requirements
Module: prim_edge_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: RAM word and colour width.
REQ-003 SHALL have parameter COORD_WIDTH, default 10: coordinate width of each line endpoint.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port load_finish, input, 1: high while the upstream ROM-to-RAM load is complete.
REQ-007 SHALL have port ram_read_addr, output, ADDR_WIDTH: base address of the current primitive record.
REQ-008 SHALL have ports ram_read_data1..ram_read_data9, input, DATA_WIDTH each: RAM[ram_read_addr+k-1] on port k.
REQ-009 SHALL have ports line_x0, line_y0, line_x1, line_y1, output, COORD_WIDTH each: current edge endpoints.
REQ-010 SHALL have port line_color, output, DATA_WIDTH: colour of the current edge.
REQ-011 SHALL have ports line_valid (output, 1) and line_ready (input, 1): edge command handshake.
REQ-012 SHALL have port line_done, input, 1: one-cycle pulse from the line rasterizer when the accepted edge is drawn.
REQ-013 SHALL have ports busy, done, error (output, 1 each) and prim_count (output, 8): status.

Function
REQ-014 SHALL treat each primitive record as 9 words: w1 type, w2..w7 x0,y0,x1,y1,x2,y2, w8 colour, w9 reserved; record stride 9.
REQ-015 SHALL decode type as 1 = LINE, 3 = TRIANGLE, 0 = END; any other value SHALL cause the ERROR state.
REQ-016 SHALL implement states IDLE, FETCH, LATCH, EMIT, WAIT_DONE, NEXT, FINISH, ERROR.
REQ-017 IDLE: SHALL leave to FETCH with base address 0 when load_finish is sampled high.
REQ-018 FETCH: SHALL hold ram_read_addr for one cycle; LATCH SHALL register all nine words on the following cycle. Read latency of 1 cycle is tolerated.
REQ-019 LATCH: on END SHALL go to FINISH; on LINE SHALL emit edge v0->v1 only; on TRIANGLE SHALL emit v0->v1, v1->v2, v2->v0 in that order.
REQ-020 SHALL take coordinates from the low COORD_WIDTH bits of each word and ignore the upper bits.
REQ-021 EMIT: SHALL assert line_valid with all line_* outputs stable until line_valid and line_ready are both high in the same cycle, then go to WAIT_DONE.
REQ-022 WAIT_DONE: SHALL deassert line_valid and wait for line_done; line_done in any other state SHALL be ignored.
REQ-023 On the last edge's line_done SHALL enter NEXT, increment prim_count (saturating at 255) and add 9 to the base address, then return to FETCH.
REQ-024 If base+9+8 exceeds 2^ADDR_WIDTH-1, NEXT SHALL enter ERROR instead of FETCH.
REQ-025 FINISH SHALL hold done=1 and ERROR SHALL hold error=1 until reset; load_finish SHALL be ignored in both.
REQ-026 busy SHALL be 1 in every state except IDLE, FINISH and ERROR.

Reset
REQ-027 With reset low at a clock edge SHALL enter IDLE, clear the base address and prim_count, and clear line_valid, busy, done and error. This applies even mid-handshake.
REQ-028 Reset values of line_x0/y0/x1/y1 and line_color SHALL be 0.

Configuration
REQ-029 With DEGENERATE_CULL_EN defined, an edge with identical endpoints SHALL be skipped without asserting line_valid, and the edge counter SHALL advance in one cycle. Without it, every edge SHALL be emitted.

Structure
REQ-030 A shared package SHALL hold the state enum, the type codes (END/LINE/TRIANGLE), the record stride 9 and the word offsets.
REQ-031 Combinational edge endpoint selection SHALL live in one sub-module, edge_select (edge index 0..2 -> endpoints).

Verification
REQ-032 Load a TRIANGLE (0,0),(10,0),(0,10) colour 0xFF at addr 0, END at 9, line_ready=1, line_done 3 cycles after each accept -> edges (0,0)-(10,0), (10,0)-(0,10), (0,10)-(0,0); done=1; prim_count=1.
REQ-033 Hold line_ready=0 for 5 cycles during EMIT -> line_valid stays 1 and the outputs stay unchanged; exactly one accept occurs.
REQ-034 Place LINE at addr 0, TRIANGLE at 9 and END at 18 -> 4 edges total, ram_read_addr sequence 0,9,18, prim_count=2.
REQ-035 Place type 7 at addr 0 -> error=1, no line_valid, done=0.
REQ-036 Assert reset low while line_valid=1 -> next cycle line_valid=0, state IDLE, prim_count=0.
REQ-037 With DEGENERATE_CULL_EN, TRIANGLE (5,5),(5,5),(8,8) -> only 2 edges emitted; without it -> 3 edges emitted.
